// File: rtl/stream_frame_writer.sv
// Video stream sink: checks sop/eop framing and writes pixels linearly into a frame buffer.
// Optional FRAME_DOUBLE_BUF_EN adds a bank bit to wr_addr and a disp_bank output.
module stream_frame_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sop_in,
  input  logic              eop_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              mem_ready,
  output logic              wr_en,
`ifdef FRAME_DOUBLE_BUF_EN
  output logic [ADDR_W:0]   wr_addr,
  output logic              disp_bank,
`else
  output logic [ADDR_W-1:0] wr_addr,
`endif
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int N = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {WAIT_SOP, ACTIVE, OVERRUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                acc;

  assign ready_out = mem_ready && !reset;
  assign acc       = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (acc) begin
      case (state_q)
        WAIT_SOP, OVERRUN: begin
          if (sop_in) begin
            // A sop out of OVERRUN also closes the runaway frame as an error.
            wr_en_d = 1'b1;
            addr_d  = '0;
            data_d  = data_in;
            if (eop_in) begin
              state_d = WAIT_SOP;
              cnt_d   = '0;
              if (N == 1 && state_q == WAIT_SOP) done_d = 1'b1;
              else                               err_d  = 1'b1;
            end else begin
              err_d = (state_q == OVERRUN);
              if (N == 1) begin
                state_d = OVERRUN;
                cnt_d   = '0;
              end else begin
                state_d = ACTIVE;
                cnt_d   = ONE;
              end
            end
          end else if (eop_in && state_q == OVERRUN) begin
            err_d   = 1'b1;
            state_d = WAIT_SOP;
            cnt_d   = '0;
          end
        end
        ACTIVE: begin
          wr_en_d = 1'b1;
          data_d  = data_in;
          if (sop_in) begin
            err_d  = 1'b1;
            addr_d = '0;
            cnt_d  = ONE;
          end else if (eop_in) begin
            addr_d  = cnt_q;
            done_d  = (cnt_q == LAST);
            err_d   = (cnt_q != LAST);
            state_d = WAIT_SOP;
            cnt_d   = '0;
          end else if (cnt_q == LAST) begin
            addr_d  = LAST;
            state_d = OVERRUN;
          end else begin
            addr_d = cnt_q;
            cnt_d  = cnt_q + ONE;
          end
        end
        default: state_d = WAIT_SOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_SOP;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = data_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

`ifdef FRAME_DOUBLE_BUF_EN
  logic bank_q;

  // Flip one cycle after frame_done so the final pixel still lands in the filled bank.
  always_ff @(posedge clk) begin
    if (reset) bank_q <= 1'b0;
    else       bank_q <= bank_q ^ done_q;
  end

  assign wr_addr   = {bank_q, addr_q};
  assign disp_bank = !bank_q;
`else
  assign wr_addr = addr_q;
`endif

endmodule

// File: tb/tb_stream_frame_writer.sv
// Directed self-checking bench for stream_frame_writer with a 4x2 frame (N=8).
module tb_stream_frame_writer;
  localparam int AW = 4;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          sop_in = 1'b0, eop_in = 1'b0, valid_in = 1'b0;
  logic          ready_out;
  logic          mem_ready = 1'b1;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          frame_done, frame_err;
`ifdef FRAME_DOUBLE_BUF_EN
  logic [AW:0]   wr_addr;
  logic          disp_bank;
`else
  logic [AW-1:0] wr_addr;
`endif

  int errors = 0;
  int checks = 0;

  stream_frame_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_in(valid_in), .ready_out(ready_out), .mem_ready(mem_ready), .wr_en(wr_en),
    .wr_addr(wr_addr),
`ifdef FRAME_DOUBLE_BUF_EN
    .disp_bank(disp_bank),
`endif
    .wr_data(wr_data), .frame_done(frame_done), .frame_err(frame_err));

  always #5 clk = ~clk;

  // Observed write/pulse bundle: {wr_en, addr, data, done, err}
  logic [AW+DW+2:0] obs;
  assign obs = {wr_en, wr_addr[AW-1:0], wr_data, frame_done, frame_err};

  function automatic logic [AW+DW+2:0] ex(input logic en, input int a, input int d,
                                          input logic dn, input logic er);
    return {en, AW'(a), DW'(d), dn, er};
  endfunction

  task automatic step(input logic v, input logic s, input logic e, input int d, input logic mr);
    valid_in = v; sop_in = s; eop_in = e; data_in = DW'(d); mem_ready = mr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 12'h0AA, 1'b1);
    step(1'b1, 1'b1, 1'b0, 12'h0AA, 1'b1);
    checks++;
    if (obs !== ex(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, ex(0, 0, 0, 0, 0));
    end
    checks++;
    if (ready_out !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", ready_out);
    end
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_clean;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, i == 7, 12'h100 + i, 1'b1);
      checks++;
      if (obs !== ex(1, i, 12'h100 + i, i == 7, 0)) begin
        errors++; $display("FAIL clean[%0d]: got %h want %h", i, obs, ex(1, i, 12'h100 + i, i == 7, 0));
      end
    end
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
    checks++;
    if (obs !== ex(0, 7, 12'h107, 0, 0)) begin
      errors++; $display("FAIL clean_idle: got %h want %h", obs, ex(0, 7, 12'h107, 0, 0));
    end
  endtask

  task automatic test_back_pressure;
    int idx = 0, pa = 7, pd = 12'h107;
    logic mr;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      mr = (cyc % 2 == 0);
      valid_in = 1'b1; sop_in = (idx == 0); eop_in = (idx == 7);
      data_in = DW'(12'h200 + idx); mem_ready = mr;
      #1;
      checks++;
      if (ready_out !== mr) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b want %b", cyc, ready_out, mr);
      end
      @(posedge clk); #1;
      checks++;
      if (mr) begin
        if (obs !== ex(1, idx, 12'h200 + idx, idx == 7, 0)) begin
          errors++; $display("FAIL bp_write[%0d]: got %h want %h", idx, obs, ex(1, idx, 12'h200 + idx, idx == 7, 0));
        end
        pa = idx; pd = 12'h200 + idx; idx++;
      end else if (obs !== ex(0, pa, pd, 0, 0)) begin
        errors++; $display("FAIL bp_stall[%0d]: got %h want %h", cyc, obs, ex(0, pa, pd, 0, 0));
      end
    end
    checks++;
    if (idx !== 8) begin
      errors++; $display("FAIL bp_count: got %0d want 8", idx);
    end
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_short;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i == 0, i == 5, 12'h500 + i, 1'b1);
      checks++;
      if (obs !== ex(1, i, 12'h500 + i, 0, i == 5)) begin
        errors++; $display("FAIL short[%0d]: got %h want %h", i, obs, ex(1, i, 12'h500 + i, 0, i == 5));
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, i == 7, 12'h600 + i, 1'b1);
      checks++;
      if (obs !== ex(1, i, 12'h600 + i, i == 7, 0)) begin
        errors++; $display("FAIL after_short[%0d]: got %h want %h", i, obs, ex(1, i, 12'h600 + i, i == 7, 0));
      end
    end
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_long;
    logic [AW+DW+2:0] e;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, i == 0, i == 10, 12'h300 + i, 1'b1);
      e = (i < 8) ? ex(1, i, 12'h300 + i, 0, 0) : ex(0, 7, 12'h307, 0, i == 10);
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL long[%0d]: got %h want %h", i, obs, e);
      end
    end
    // Non-sop beat must be dropped if the block went back to waiting for sop.
    step(1'b1, 1'b0, 1'b0, 12'h3FF, 1'b1);
    checks++;
    if (obs !== ex(0, 7, 12'h307, 0, 0)) begin
      errors++; $display("FAIL long_wait_sop: got %h want %h", obs, ex(0, 7, 12'h307, 0, 0));
    end
  endtask

  task automatic test_restart;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 12'h400 + i, 1'b1);
      checks++;
      if (obs !== ex(0, 7, 12'h307, 0, 0)) begin
        errors++; $display("FAIL garbage[%0d]: got %h want %h", i, obs, ex(0, 7, 12'h307, 0, 0));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, 1'b0, 12'h410 + i, 1'b1);
      checks++;
      if (obs !== ex(1, i, 12'h410 + i, 0, 0)) begin
        errors++; $display("FAIL pre_restart[%0d]: got %h want %h", i, obs, ex(1, i, 12'h410 + i, 0, 0));
      end
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b1, j == 0, j == 7, 12'h420 + j, 1'b1);
      checks++;
      if (obs !== ex(1, j, 12'h420 + j, j == 7, j == 0)) begin
        errors++; $display("FAIL restart[%0d]: got %h want %h", j, obs, ex(1, j, 12'h420 + j, j == 7, j == 0));
      end
    end
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, 1'b0, 12'h700 + i, 1'b1);
      checks++;
      if (obs !== ex(1, i, 12'h700 + i, 0, 0)) begin
        errors++; $display("FAIL mid_pre[%0d]: got %h want %h", i, obs, ex(1, i, 12'h700 + i, 0, 0));
      end
    end
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 12'h704, 1'b1);
    checks++;
    if (obs !== ex(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL mid_reset: got %h want %h", obs, ex(0, 0, 0, 0, 0));
    end
`ifdef FRAME_DOUBLE_BUF_EN
    checks++;
    if ({wr_addr[AW], disp_bank} !== 2'b01) begin
      errors++; $display("FAIL mid_bank_reset: got %b want 01", {wr_addr[AW], disp_bank});
    end
`endif
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0, 12'h705, 1'b1);
    checks++;
    if (obs !== ex(0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL mid_abandon: got %h want %h", obs, ex(0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, i == 7, 12'h800 + i, 1'b1);
      checks++;
      if (obs !== ex(1, i, 12'h800 + i, i == 7, 0)) begin
        errors++; $display("FAIL mid_after[%0d]: got %h want %h", i, obs, ex(1, i, 12'h800 + i, i == 7, 0));
      end
`ifdef FRAME_DOUBLE_BUF_EN
      checks++;
      if ({wr_addr[AW], disp_bank} !== 2'b01) begin
        errors++; $display("FAIL mid_bank[%0d]: got %b want 01", i, {wr_addr[AW], disp_bank});
      end
`endif
    end
    step(1'b0, 1'b0, 1'b0, 0, 1'b1);
`ifdef FRAME_DOUBLE_BUF_EN
    checks++;
    if ({wr_addr[AW], disp_bank} !== 2'b10) begin
      errors++; $display("FAIL mid_bank_flip: got %b want 10", {wr_addr[AW], disp_bank});
    end
`endif
    checks++;
    if (obs !== ex(0, 7, 12'h807, 0, 0)) begin
      errors++; $display("FAIL mid_idle: got %h want %h", obs, ex(0, 7, 12'h807, 0, 0));
    end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_back_pressure;
    test_short;
    test_long;
    test_restart;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
